// File: rtl/logic_pipe.sv
// logic_pipe: elastic bitwise-logic pipeline with a saturating hit counter
module logic_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic [CNT_W-1:0] hit_cnt,
  input  logic             cnt_clr,
  output logic             busy
);
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] h;
  logic [STAGES-1:0] ld;
  logic [WIDTH-1:0]  r [STAGES];
  logic [WIDTH-1:0]  res;
  logic              hit;
  // stage-1 operation and hit flag
  always_comb begin
    hit = &(a & b);
    res = op == 2'b00 ? a & b :
          op == 2'b01 ? a | b :
          op == 2'b10 ? a ^ b :
          (&a && &b)  ? a & b : '0;
  end
  // a stage can load when out_ready is high or it or any later stage is empty
  always_comb begin
    for (int k = 0; k < STAGES; k++)
      ld[k] = out_ready || |(~v >> k);
  end
  assign in_ready  = rst_n && ld[0];
  assign out_valid = v[STAGES-1];
  assign c         = r[STAGES-1];
  assign busy      = |v;
  // pipeline registers: each stage loads from the one before when free
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v <= '0;
      h <= '0;
      for (int k = 0; k < STAGES; k++) r[k] <= '0;
    end else begin
      if (ld[0]) begin
        v[0] <= in_valid;
        h[0] <= hit;
        r[0] <= res;
      end
      for (int k = 1; k < STAGES; k++)
        if (ld[k]) begin
          v[k] <= v[k-1];
          h[k] <= h[k-1];
          r[k] <= r[k-1];
        end
    end
  end
  // saturating count of delivered hits; clear wins over increment
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) hit_cnt <= '0;
    else if (out_valid && out_ready && h[STAGES-1] && !(&hit_cnt)) hit_cnt <= hit_cnt + 1'b1;
  end
endmodule

// File: tb/tb_logic_pipe.sv
// tb_logic_pipe: directed and random checks of logic_pipe against a queue model
module tb_logic_pipe;
  localparam int W = 8, S = 2, CW = 4, CMAX = (1 << CW) - 1;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, cnt_clr = 0;
  logic in_ready, out_valid, busy;
  logic [W-1:0] a = '0, b = '0, c;
  logic [1:0] op = '0;
  logic [CW-1:0] hit_cnt;
  int errors = 0, checks = 0;
  logic [W:0] q[$];
  int cnt = 0, cyc = 0, acc_n = 0, del_n = 0, first_del = -1, last_del = -1;

  always #5 clk = ~clk;

  logic_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .hit_cnt(hit_cnt), .cnt_clr(cnt_clr), .busy(busy)
  );

  function automatic logic [W:0] ref_op(logic [1:0] o, logic [W-1:0] x, logic [W-1:0] y);
    logic [W-1:0] rr;
    case (o)
      2'd0: rr = x & y;
      2'd1: rr = x | y;
      2'd2: rr = x ^ y;
      default: rr = (x == '1 && y == '1) ? '1 : '0;
    endcase
    return {(x & y) == '1, rr};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic acc, del, hf;
    logic [W-1:0] cv;
    logic [W:0] e;
    #1;
    acc = rst_n && in_valid && in_ready;
    del = rst_n && out_valid && out_ready;
    cv = c;
    e = ref_op(op, a, b);
    hf = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n) begin
      q.delete();
      cnt = 0;
    end else begin
      if (del) begin
        chk("out_has_entry", q.size() != 0, 1);
        if (q.size() != 0) begin
          chk("c_order", cv, q[0][W-1:0]);
          hf = q[0][W];
          void'(q.pop_front());
          del_n++;
          if (first_del < 0) first_del = cyc;
          last_del = cyc;
        end
      end
      cnt = cnt_clr ? 0 : (del && hf && cnt < CMAX) ? cnt + 1 : cnt;
      if (acc) begin
        q.push_back(e);
        acc_n++;
      end
    end
    chk("hit_cnt", hit_cnt, cnt);
    chk("busy", busy, q.size() != 0);
    chk("in_ready", in_ready, rst_n && (out_ready || q.size() < S));
    chk("out_valid_no_phantom", out_valid && q.size() == 0, 0);
  endtask

  initial begin
    // reset
    rst_n = 0;
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_c", c, 0);
    chk("rst_in_ready", in_ready, 0);
    rst_n = 1;
    #1 chk("rdy_after_rst", in_ready, 1);
    // AND latency: presented in cycle 0, out_valid in cycle 2
    out_ready = 1; a = 8'hF0; b = 8'h3C; op = 2'b00; in_valid = 1;
    tick();
    in_valid = 0;
    chk("lat_cycle1", out_valid, 0);
    tick();
    chk("lat_cycle2", out_valid, 1);
    chk("and_c", c, 8'h30);
    tick();
    // gated AND hit and miss
    op = 2'b11; a = 8'hFF; b = 8'hFF; in_valid = 1;
    tick();
    in_valid = 0;
    tick();
    chk("gand_ff_c", c, 8'hFF);
    tick();
    chk("gand_ff_cnt", hit_cnt, 1);
    b = 8'hFE; in_valid = 1;
    tick();
    in_valid = 0;
    tick();
    chk("gand_fe_c", c, 8'h00);
    tick();
    chk("gand_fe_cnt", hit_cnt, 1);
    // backpressure: 10 back-to-back, out_ready low
    out_ready = 0; in_valid = 1; acc_n = 0;
    for (int i = 0; i < 10; i++) begin
      a = W'($urandom); b = W'($urandom); op = 2'($urandom);
      tick();
    end
    chk("stall_accepted", acc_n, 2);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_out_hold", c, q[0][W-1:0]);
    out_ready = 1; del_n = 0; first_del = -1;
    for (int i = 0; i < 40 && del_n < 10; i++) begin
      if (acc_n >= 10) in_valid = 0;
      a = W'($urandom); b = W'($urandom); op = 2'($urandom);
      tick();
    end
    in_valid = 0;
    chk("stream_count", del_n, 10);
    chk("stream_no_gaps", last_del - first_del + 1, 10);
    // saturation with 20 hits
    a = 8'hFF; b = 8'hFF; in_valid = 1;
    for (int i = 0; i < 20; i++) begin
      op = 2'($urandom);
      tick();
    end
    in_valid = 0;
    repeat (3) tick();
    chk("sat_cnt", hit_cnt, CMAX);
    // clear coinciding with a hit delivery
    in_valid = 1;
    tick();
    in_valid = 0;
    tick();
    chk("clr_out_valid", out_valid, 1);
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    chk("clr_wins", hit_cnt, 0);
    // random traffic
    for (int i = 0; i < 1000; i++) begin
      in_valid = 1'($urandom);
      out_ready = 1'($urandom);
      a = ($urandom % 4 == 0) ? '1 : W'($urandom);
      b = ($urandom % 4 == 0) ? '1 : W'($urandom);
      op = 2'($urandom);
      cnt_clr = ($urandom % 64 == 0);
      tick();
    end
    in_valid = 0; out_ready = 1; cnt_clr = 0;
    for (int i = 0; i < 10 && q.size() != 0; i++) tick();
    chk("drain_empty", q.size(), 0);
    chk("drain_out_valid", out_valid, 0);
    // reset with two entries in flight
    a = 8'hFF; b = 8'hFF; op = 2'b00; in_valid = 1;
    tick();
    in_valid = 0;
    tick();
    tick();
    chk("pre_rst_cnt_nz", hit_cnt != 0, 1);
    out_ready = 0; in_valid = 1;
    tick();
    tick();
    chk("inflight_busy", busy, 1);
    chk("inflight_out_valid", out_valid, 1);
    rst_n = 0;
    #1 chk("rdy_in_rst", in_ready, 0);
    tick();
    in_valid = 0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cnt", hit_cnt, 0);
    rst_n = 1;
    #1 chk("midrst_rdy", in_ready, 1);
    out_ready = 1;
    tick();
    tick();
    chk("midrst_no_output", out_valid, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/logic_pipe.md
LOGIC_PIPE -- requirements
Module: logic_pipe

Interface
REQ-001 SHALL: parameter WIDTH, default 8, operand/result width (1..32).
REQ-002 SHALL: parameter STAGES, default 2, pipeline register stages (1..4).
REQ-003 SHALL: parameter CNT_W, default 16, hit-counter width.
REQ-004 SHALL: clk  input  1  single clock; all state changes on rising edge only.
REQ-005 SHALL: rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL: in_valid  input  1  input transaction offered.
REQ-007 SHALL: in_ready  output  1  pipeline accepts input this cycle.
REQ-008 SHALL: a  input  WIDTH  operand A.
REQ-009 SHALL: b  input  WIDTH  operand B.
REQ-010 SHALL: op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 GATED-AND.
REQ-011 SHALL: out_valid  output  1  result available.
REQ-012 SHALL: out_ready  input  1  downstream accepts result.
REQ-013 SHALL: c  output  WIDTH  result.
REQ-014 SHALL: hit_cnt  output  CNT_W  saturating count of delivered hit transactions.
REQ-015 SHALL: cnt_clr  input  1  synchronous clear of hit_cnt.
REQ-016 SHALL: busy  output  1  high when any stage holds a valid entry.

Function
REQ-017 SHALL: accept a transaction when in_valid && in_ready on a rising edge; a, b, op sampled that edge.
REQ-018 SHALL: compute result at stage 1: AND a&b; OR a|b; XOR a^b; GATED-AND a&b when a and b are both all-ones, else all-zeros.
REQ-019 SHALL: compute hit = &(a & b) at stage 1 and carry it with the result through all stages.
REQ-020 SHALL: hold STAGES register stages, each with valid bit, result and hit flag; c and out_valid driven directly from the last stage.
REQ-021 SHALL: latency exactly STAGES cycles accept-to-out_valid when out_ready is held high.
REQ-022 SHALL: sustain throughput of one transaction per cycle with out_ready held high.
REQ-023 SHALL: advance stage k when stage k+1 is empty or advancing; last stage advances on out_ready or when empty.
REQ-024 SHALL: in_ready = stage 1 empty or stage 1 advancing (combinational, no extra bubble).
REQ-025 SHALL: while out_valid && !out_ready, hold c and out_valid stable; no entry lost, duplicated or reordered.
REQ-026 SHALL: pipeline full (all STAGES valid) with out_ready low -> in_ready low.
REQ-027 SHALL: increment hit_cnt by 1 on each out_valid && out_ready whose hit flag is 1.
REQ-028 SHALL: saturate hit_cnt at 2^CNT_W-1; no wrap.
REQ-029 SHALL: cnt_clr high -> hit_cnt = 0 next edge; cnt_clr beats a simultaneous increment.
REQ-030 SHALL: cnt_clr does not affect pipeline contents or handshakes.
REQ-031 SHALL: busy = OR of all stage valid bits.

Reset
REQ-032 SHALL: rst_n low at an edge -> all valid bits 0, c = 0, hit_cnt = 0, busy = 0.
REQ-033 SHALL: in_ready driven 0 while rst_n is low; 1 on first cycle after rst_n high.
REQ-034 SHALL: reset mid-operation discards all in-flight entries; no partial output afterwards.
REQ-035 SHALL: no transaction accepted on an edge where rst_n is low.

Verification
REQ-036 SHALL: WIDTH=8, STAGES=2, op=00, a=0xF0, b=0x3C, out_ready=1 -> c=0x30, out_valid exactly 2 cycles after accept.
REQ-037 SHALL: op=11, a=0xFF, b=0xFF -> c=0xFF, hit_cnt +1; op=11, a=0xFF, b=0xFE -> c=0x00, hit_cnt unchanged.
REQ-038 SHALL: stream 10 back-to-back ops with out_ready=0 -> in_ready low after 2 accepted; release out_ready -> all 10 results in order, no gaps once flowing.
REQ-039 SHALL: CNT_W=4, 20 hit transactions -> hit_cnt stays 15; cnt_clr asserted with a hit delivery -> hit_cnt=0.
REQ-040 SHALL: rst_n low for 1 cycle with 2 entries in flight -> out_valid=0, busy=0, hit_cnt=0; in_ready=1 next cycle.
REQ-041 SHALL: random in_valid/out_ready over 1000 cycles, all op codes -> output sequence equals reference model, every transaction exactly once.
